display_scheduler: RTL
======================

Name: display_scheduler

Overview:
Time-shares the six-digit seven-segment display between up to N_REQ requesters, such as the strobe counter, the FSM output counters and the rotary encoder value. Requesters are served round-robin. Each requester holds the display for DWELL ticks of an external strobe, typically the shift strobe. A manual mode pins the display to one requester. The block sits between the number sources and the seven_segment_digit instances, replacing the static switch-driven display mux.

Parameters:
N_REQ, 4, number of requesters (2..8)
ID_W, 2, width of requester index (clog2 N_REQ)
DATA_W, 24, width of each requester's display word (6 hex digits)
DWELL, 16, tick strobes per turn before rotation (>=1)
CNT_W, 5, width of dwell counter (holds DWELL)

Ports:
clk  in  1  system clock
reset_n  in  1  synchronous reset, active low
tick  in  1  dwell strobe, one-cycle pulse
req  in  N_REQ  per-requester "has something to show"
data  in  N_REQ*DATA_W  requester words, requester i at [i*DATA_W +: DATA_W]
manual  in  1  1 = manual mode
manual_sel  in  ID_W  requester selected in manual mode
urgent  in  N_REQ  preemption requests (used only with DISPLAY_SCHED_URGENT_EN)
grant  out  N_REQ  one-hot current owner, 0 when idle
owner_id  out  ID_W  index of current owner
disp_data  out  DATA_W  registered display word
blank  out  1  1 = nothing to show; digits must be blanked
switch_pulse  out  1  one-cycle pulse whenever the owner changes or goes idle

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low (reset_n). Every output is registered.
- Reset values:
  - state=IDLE, grant=0, owner_id=0, disp_data=0, blank=1, switch_pulse=0
  - dwell_cnt=0
  - rr_ptr=N_REQ-1, so the first search starts at requester 0
- States: IDLE, SHOW.
- Round-robin pick: first i with req[i]=1, searching rr_ptr+1, rr_ptr+2, ... modulo N_REQ. The search wraps and includes rr_ptr itself last.
- IDLE:
  - If |req: next edge goes to SHOW with owner=pick, grant=onehot(pick), rr_ptr=pick, dwell_cnt=0, blank=0, switch_pulse=1.
  - Otherwise stay in IDLE.
- SHOW, auto mode (manual=0), priority order:
  1. req[owner]=0 (owner withdrew): if another req exists, switch to pick; else go to IDLE with grant=0, blank=1, disp_data=0. Either way switch_pulse=1 and dwell_cnt=0.
  2. tick=1 and dwell_cnt==DWELL-1: rotate to pick. If pick==owner (sole requester), the owner is kept, switch_pulse=0, and dwell_cnt=0.
  3. tick=1: dwell_cnt+1.
- Manual mode (manual=1):
  - The owner is forced to manual_sel whenever req[manual_sel]=1; otherwise the block goes to IDLE.
  - Dwell is frozen at 0 and tick is ignored.
  - switch_pulse fires on each owner change, including the transition caused by entering or leaving manual mode.
  - On return to manual=0 the current owner is kept, rr_ptr=owner, and dwell restarts at 0.
- disp_data: each cycle in SHOW, disp_data<=data slice of the next-state owner. This gives one cycle of latency from data to disp_data and makes disp_data, grant and owner_id change on the same edge.
- Simultaneous events:
  - Owner withdrawal beats dwell expiry.
  - A tick on the switching cycle is not counted.
  - Reset beats everything. Asserting reset_n=0 mid-SHOW returns to the reset values on the next edge.
- Requesters with req=0 are never granted. grant is always one-hot or zero.

Optional Feature:
DISPLAY_SCHED_URGENT_EN
- Defined:
  - In auto-mode SHOW, any urgent[i]&req[i] with i!=owner preempts the current owner on the next edge. The chosen i is the first urgent requester in round-robin order from rr_ptr+1. dwell_cnt=0, switch_pulse=1.
  - An urgent owner is not preempted by another urgent requester until its dwell expires.
  - Urgent preemption ranks below owner withdrawal and above dwell expiry.
  - In IDLE, urgent requesters are picked before non-urgent ones.
  - Manual mode ignores urgent.
- Undefined: the urgent port exists but is ignored, and behaviour is pure round-robin.

Test Plan:
- Reset then hold at req=0 -> blank=1, grant=0, disp_data=0, switch_pulse stays 0.
- req=4'b1111, DWELL=16, tick every 4 clocks, data[i]=24'h00000i+1:
  - grant sequence is 0001, 0010, 0100, 1000, 0001, ...
  - each owner lasts exactly 16 ticks
  - disp_data equals the owner's word one cycle after the owner is selected
  - one switch_pulse per change
- req=4'b0100 only -> grant stays 0100 across multiple dwell expiries, and switch_pulse never fires after the first grant.
- Owner 1 drops req mid-dwell with req=4'b1010 -> next edge grant=1000, dwell_cnt=0. Then drop all req -> IDLE, blank=1, switch_pulse=1.
- Manual mode:
  - manual=1, manual_sel=2, req=4'b0101 -> grant=0100 regardless of ticks.
  - Clear req[2] -> blank=1.
  - manual=0 -> round-robin resumes from 2.
- With DISPLAY_SCHED_URGENT_EN defined, owner 0 in SHOW, urgent=4'b1000, req=4'b1001 -> grant=1000 on the next edge. Without the macro, grant stays 0001 until dwell expiry.

Source files
------------

// File: rtl/display_scheduler.sv
// display_scheduler: time-shares the six-digit seven-segment display between
// N_REQ number sources. Owners are chosen round-robin and each holds the
// display for DWELL ticks of an external strobe. Manual mode pins the display
// to manual_sel.
//
// Optional feature macro: DISPLAY_SCHED_URGENT_EN. When defined, urgent[i]
// lets a requester preempt a non-urgent owner and be picked first from idle.
// When undefined the urgent port is ignored.
//
// Ports:
//   clk          system clock
//   reset_n      synchronous reset, active low
//   tick         dwell strobe, one-cycle pulse
//   req          per-requester "has something to show"
//   data         requester words, requester i at [i*DATA_W +: DATA_W]
//   manual       1 = manual mode
//   manual_sel   requester shown in manual mode
//   urgent       preemption requests (feature macro only)
//   grant        one-hot current owner, 0 when idle
//   owner_id     index of current owner
//   disp_data    registered display word of the owner
//   blank        1 = nothing to show
//   switch_pulse one-cycle pulse when the owner changes or goes idle
module display_scheduler #(
  parameter int unsigned N_REQ  = 4,
  parameter int unsigned ID_W   = 2,
  parameter int unsigned DATA_W = 24,
  parameter int unsigned DWELL  = 16,
  parameter int unsigned CNT_W  = 5
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    tick,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*DATA_W-1:0] data,
  input  logic                    manual,
  input  logic [ID_W-1:0]         manual_sel,
  input  logic [N_REQ-1:0]        urgent,
  output logic [N_REQ-1:0]        grant,
  output logic [ID_W-1:0]         owner_id,
  output logic [DATA_W-1:0]       disp_data,
  output logic                    blank,
  output logic                    switch_pulse
);

  typedef enum logic [0:0] {StIdle, StShow} state_e;

  state_e            state_q, state_d;
  logic [ID_W-1:0]   owner_q, owner_d;
  logic [ID_W-1:0]   rr_q, rr_d;
  logic [CNT_W-1:0]  dwell_q, dwell_d;
  logic [N_REQ-1:0]  grant_q, grant_d;
  logic [DATA_W-1:0] disp_q, disp_d;
  logic              blank_q, blank_d;
  logic              pulse_q, pulse_d;

  // Returns {found, index}: first set bit of mask searching ptr+1, ptr+2, ...
  // modulo N_REQ, with ptr itself examined last.
  function automatic logic [ID_W:0] rr_pick(input logic [N_REQ-1:0] mask,
                                            input logic [ID_W-1:0] ptr);
    logic [ID_W:0] r;
    int            idx;
    r = '0;
    for (int k = 1; k <= int'(N_REQ); k++) begin
      idx = (int'(ptr) + k) % int'(N_REQ);
      if (!r[ID_W] && mask[idx]) begin
        r = {1'b1, ID_W'(idx)};
      end
    end
    return r;
  endfunction

  logic            pick_found;
  logic [ID_W-1:0] pick_id;
  logic            idle_found;
  logic [ID_W-1:0] idle_id;
  logic            pre_found;
  logic [ID_W-1:0] pre_id;
  logic            manual_ok;

  always_comb begin
    {pick_found, pick_id} = rr_pick(req, rr_q);
`ifdef DISPLAY_SCHED_URGENT_EN
    // A non-urgent owner yields to any urgent requester; an urgent owner
    // keeps the display until its dwell expires.
    {pre_found, pre_id} = rr_pick(req & urgent, rr_q);
    if (urgent[owner_q]) begin
      pre_found = 1'b0;
    end
    if (|(req & urgent)) begin
      {idle_found, idle_id} = rr_pick(req & urgent, rr_q);
    end else begin
      idle_found = pick_found;
      idle_id    = pick_id;
    end
`else
    pre_found  = 1'b0;
    pre_id     = '0;
    idle_found = pick_found;
    idle_id    = pick_id;
`endif
  end

  // Out-of-range selections (non power-of-two N_REQ) count as no request.
  assign manual_ok = (int'(manual_sel) < int'(N_REQ)) && req[manual_sel];

`ifndef DISPLAY_SCHED_URGENT_EN
  logic unused_urgent;
  assign unused_urgent = ^{urgent, pre_found, pre_id};
`endif

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    rr_d    = rr_q;
    dwell_d = dwell_q;

    unique case (state_q)
      StIdle: begin
        if (manual) begin
          if (manual_ok) begin
            state_d = StShow;
            owner_d = manual_sel;
            rr_d    = manual_sel;
            dwell_d = '0;
          end
        end else if (idle_found) begin
          state_d = StShow;
          owner_d = idle_id;
          rr_d    = idle_id;
          dwell_d = '0;
        end
      end
      StShow: begin
        if (manual) begin
          // rr_ptr follows the pinned owner so auto mode resumes after it.
          dwell_d = '0;
          if (manual_ok) begin
            owner_d = manual_sel;
            rr_d    = manual_sel;
          end else begin
            state_d = StIdle;
          end
        end else if (!req[owner_q]) begin
          dwell_d = '0;
          if (pick_found) begin
            owner_d = pick_id;
            rr_d    = pick_id;
          end else begin
            state_d = StIdle;
          end
        end else if (pre_found) begin
          owner_d = pre_id;
          rr_d    = pre_id;
          dwell_d = '0;
        end else if (tick) begin
          if (dwell_q == CNT_W'(DWELL - 1)) begin
            // pick always succeeds here since the owner still requests.
            owner_d = pick_id;
            rr_d    = pick_id;
            dwell_d = '0;
          end else begin
            dwell_d = dwell_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    if (state_d == StShow) begin
      grant_d = N_REQ'(1) << owner_d;
      disp_d  = data[int'(owner_d)*int'(DATA_W) +: DATA_W];
      blank_d = 1'b0;
    end else begin
      grant_d = '0;
      disp_d  = '0;
      blank_d = 1'b1;
    end

    pulse_d = ((state_d == StShow) && ((state_q == StIdle) || (owner_d != owner_q))) ||
              ((state_d == StIdle) && (state_q == StShow));
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= StIdle;
      owner_q <= '0;
      rr_q    <= ID_W'(N_REQ - 1);
      dwell_q <= '0;
      grant_q <= '0;
      disp_q  <= '0;
      blank_q <= 1'b1;
      pulse_q <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      rr_q    <= rr_d;
      dwell_q <= dwell_d;
      grant_q <= grant_d;
      disp_q  <= disp_d;
      blank_q <= blank_d;
      pulse_q <= pulse_d;
    end
  end

  assign grant        = grant_q;
  assign owner_id     = owner_q;
  assign disp_data    = disp_q;
  assign blank        = blank_q;
  assign switch_pulse = pulse_q;

endmodule
